// File: rtl/div_result_bcd.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) for the divider result.
// A divider error is forwarded as an all-0xF digit pattern with Err_out set.
module div_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  Go,
  input  logic                  Error,
  input  logic [WIDTH-1:0]      bin,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  Done,
  output logic                  Busy,
  output logic                  Err_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // DIGITS must be able to hold the largest WIDTH-bit value.
  generate
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_size_chk
      $fatal(1, "div_result_bcd: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [WIDTH-1:0]      sreg;
  logic [4*DIGITS-1:0]   scratch;
  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS-1:0]   scr_nxt;
  logic [CW-1:0]         cnt;
  logic                  last;

  // Add-3 correction on every digit in parallel, ahead of the shift.
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    assign adj[4*d +: 4] = (scratch[4*d +: 4] >= 4'd5) ? scratch[4*d +: 4] + 4'd3
                                                        : scratch[4*d +: 4];
  end

  assign scr_nxt = {adj[4*DIGITS-2:0], sreg[WIDTH-1]};
  assign last    = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Done      = 1'b0;
    Busy      = 1'b0;
    case (state)
      IDLE:  if (Go) state_nxt = Error ? DONE : SHIFT;
      SHIFT: begin
        Busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      sreg    <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      Err_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Go) begin
          if (Error) begin
            bcd     <= '1;
            Err_out <= 1'b1;
          end else begin
            sreg    <= bin;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          scratch <= scr_nxt;
          sreg    <= sreg << 1;
          if (last) begin
            bcd     <= scr_nxt;
            Err_out <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_result_bcd.sv
// Directed bench for div_result_bcd: vector table of conversions plus multi-cycle corner sequences.
module tb_div_result_bcd;
  logic        CLK = 1'b0;
  logic        rst, Go, Error;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic        Done, Busy, Err_out;

  int checks = 0;
  int errors = 0;

  div_result_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .CLK(CLK), .rst(rst), .Go(Go), .Error(Error), .bin(bin),
    .bcd(bcd), .Done(Done), .Busy(Busy), .Err_out(Err_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  bin;
    logic        err;
    logic [11:0] exp_bcd;
    logic        exp_eo;
  } vec_t;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One Go pulse; measures edges from the sampling edge to Done and Busy cycles.
  task automatic run_conv(input logic [7:0] b, input logic e, input logic [11:0] xb,
                          input logic xe, input string nm);
    int n, bsy;
    Go = 1'b1; Error = e; bin = b;
    step();
    Go = 1'b0; Error = ~e; bin = ~b;
    n = 0; bsy = 0;
    while (!Done && n < 20) begin
      if (Busy) bsy++;
      step();
      n++;
    end
    chk({nm, " latency"}, n, e ? 0 : 8);
    chk({nm, " busy cycles"}, bsy, e ? 0 : 8);
    chk({nm, " bcd"}, {20'd0, bcd}, {20'd0, xb});
    chk({nm, " err_out"}, {31'd0, Err_out}, {31'd0, xe});
    step();
    chk({nm, " done width"}, {31'd0, Done}, 32'd0);
    Error = 1'b0;
  endtask

  initial begin
    vec_t vecs[9];
    int dones, first, prev, nd;

    vecs[0] = '{8'd255, 1'b0, 12'h255, 1'b0};
    vecs[1] = '{8'd0,   1'b0, 12'h000, 1'b0};
    vecs[2] = '{8'd100, 1'b0, 12'h100, 1'b0};
    vecs[3] = '{8'd9,   1'b0, 12'h009, 1'b0};
    vecs[4] = '{8'd37,  1'b1, 12'hFFF, 1'b1};
    vecs[5] = '{8'd37,  1'b0, 12'h037, 1'b0};
    vecs[6] = '{8'd99,  1'b0, 12'h099, 1'b0};
    vecs[7] = '{8'd128, 1'b0, 12'h128, 1'b0};
    vecs[8] = '{8'd1,   1'b0, 12'h001, 1'b0};

    rst = 1'b1; Go = 1'b0; Error = 1'b0; bin = 8'd0;
    step(); step();
    rst = 1'b0;
    chk("reset bcd",  {20'd0, bcd}, 32'd0);
    chk("reset done", {31'd0, Done}, 32'd0);
    chk("reset busy", {31'd0, Busy}, 32'd0);
    chk("reset err",  {31'd0, Err_out}, 32'd0);

    for (int i = 0; i < 9; i++)
      run_conv(vecs[i].bin, vecs[i].err, vecs[i].exp_bcd, vecs[i].exp_eo, $sformatf("vec%0d", i));

    // Go re-asserted during SHIFT must be ignored.
    Go = 1'b1; bin = 8'd200;
    step();
    bin = 8'd5;
    step(); step(); step();
    Go = 1'b0;
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      if (Done) dones++;
      step();
    end
    chk("go ignored dones", dones, 1);
    chk("go ignored bcd", {20'd0, bcd}, 32'h200);

    // Reset in the 4th SHIFT cycle.
    Go = 1'b1; bin = 8'd199;
    step();
    Go = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst bcd",  {20'd0, bcd}, 32'd0);
    chk("midrst done", {31'd0, Done}, 32'd0);
    chk("midrst busy", {31'd0, Busy}, 32'd0);
    chk("midrst err",  {31'd0, Err_out}, 32'd0);
    run_conv(8'd42, 1'b0, 12'h042, 1'b0, "after rst");

    // Go held high: Done every WIDTH+2 cycles.
    Go = 1'b1; bin = 8'd58; Error = 1'b0;
    nd = 0; first = -1; prev = -1;
    for (int c = 0; c < 41; c++) begin
      step();
      if (Done) begin
        nd++;
        chk("held bcd", {20'd0, bcd}, 32'h058);
        if (prev < 0) first = c;
        else chk("held period", c - prev, 10);
        prev = c;
      end
    end
    chk("held first done", first, 8);
    chk("held pulse count", nd, 4);
    Go = 1'b0;
    for (int c = 0; c < 12; c++) step();
    chk("held drain idle", {31'd0, Busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
